// File: rtl/register_file_reader.sv
// register_file_reader
//
// Walks an inclusive, optionally wrapping address range on one read port of
// the register file. Each word is streamed out with its address over a
// valid/ready handshake, at up to one word per cycle.
//
// Ports
//   clk        clock, rising edge
//   clr        asynchronous active-low reset
//   start      begin a scan (honoured only in IDLE with abort low)
//   first      first address of the scan, sampled on start
//   last       last address of the scan (inclusive), sampled on start
//   abort      end the current scan early, without a done pulse
//   rf_addr    read address to the register file (the scan pointer)
//   rf_data    combinational read data for rf_addr
//   out_data   streamed word
//   out_addr   address the streamed word was read from
//   out_valid  out_data/out_addr valid
//   out_ready  consumer accepts the word this cycle
//   busy       scan in progress
//   done       one-cycle pulse on normal completion
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; output register empty
// SCAN   | words left to read; loads whenever the output slot is free
// DRAIN  | last word loaded, waiting for it to be accepted

module register_file_reader #(
  parameter int WORDS        = 16,
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] first,
  input  logic [ADDRESS_BITS-1:0] last,
  input  logic                    abort,
  output logic [ADDRESS_BITS-1:0] rf_addr,
  input  logic [BITS-1:0]         rf_data,
  output logic [BITS-1:0]         out_data,
  output logic [ADDRESS_BITS-1:0] out_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDRESS_BITS-1:0] MAX_ADDR = ADDRESS_BITS'(WORDS - 1);

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] ptr_q, ptr_d;
  logic [ADDRESS_BITS-1:0] last_q, last_d;
  logic [BITS-1:0]         odata_q, odata_d;
  logic [ADDRESS_BITS-1:0] oaddr_q, oaddr_d;
  logic                    ovalid_q, ovalid_d;
  logic                    done_q, done_d;

  logic [ADDRESS_BITS-1:0] first_clamped;
  logic [ADDRESS_BITS-1:0] last_clamped;
  logic [ADDRESS_BITS-1:0] ptr_next;
  logic                    start_ok;
  logic                    load;
  logic                    take;
  logic                    aborting;

  // Out-of-range addresses only exist when WORDS is not a power of two.
  generate
    if ((2 ** ADDRESS_BITS) > WORDS) begin : g_clamp
      assign first_clamped = (first > MAX_ADDR) ? MAX_ADDR : first;
      assign last_clamped  = (last  > MAX_ADDR) ? MAX_ADDR : last;
    end else begin : g_no_clamp
      assign first_clamped = first;
      assign last_clamped  = last;
    end
  endgenerate

  // Explicit wrap so non-power-of-two files still cycle through 0.
  assign ptr_next = (ptr_q == MAX_ADDR) ? '0 : ptr_q + 1'b1;

  assign start_ok = (state_q == ST_IDLE) && start && !abort;
  assign aborting = (state_q != ST_IDLE) && abort;
  assign take     = ovalid_q && out_ready;
  assign load     = (state_q == ST_SCAN) && (!ovalid_q || out_ready) && !abort;

  // State register and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      last_q   <= '0;
      odata_q  <= '0;
      oaddr_q  <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      odata_q  <= odata_d;
      oaddr_q  <= oaddr_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort)                          state_d = ST_IDLE;
        else if (load && (ptr_q == last_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)     state_d = ST_IDLE;
        else if (take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next-values
  always_comb begin
    ptr_d    = ptr_q;
    last_d   = last_q;
    odata_d  = odata_q;
    oaddr_d  = oaddr_q;
    ovalid_d = ovalid_q;
    done_d   = 1'b0;

    if (start_ok) begin
      ptr_d  = first_clamped;
      last_d = last_clamped;
    end

    // A word handshaken alongside abort is simply gone: it was delivered.
    if (aborting) begin
      ovalid_d = 1'b0;
    end else if (load) begin
      odata_d  = rf_data;
      oaddr_d  = ptr_q;
      ovalid_d = 1'b1;
      // Pointer parks on the final address; it is reloaded on the next start.
      if (ptr_q != last_q) ptr_d = ptr_next;
    end else if (take) begin
      ovalid_d = 1'b0;
    end

    if ((state_q == ST_DRAIN) && take && !abort) done_d = 1'b1;
  end

  assign rf_addr   = ptr_q;
  assign out_data  = odata_q;
  assign out_addr  = oaddr_q;
  assign out_valid = ovalid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_register_file_reader.sv
// Directed bench for register_file_reader: a behavioural register file
// preloaded with 100+i, hand-computed expected address/data sequences.

module tb_register_file_reader;

  localparam int WORDS = 16;
  localparam int BITS  = 32;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic            abort;
  logic            out_ready;
  logic [AW-1:0]   first;
  logic [AW-1:0]   last;
  logic [AW-1:0]   rf_addr;
  logic [AW-1:0]   out_addr;
  logic [BITS-1:0] rf_data;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            busy;
  logic            done;

  logic [BITS-1:0] mem [WORDS];
  assign rf_data = mem[rf_addr];

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0]   got_addr [$];
  logic [BITS-1:0] got_data [$];
  int              done_seen;

  always #5 clk = ~clk;

  register_file_reader #(
    .WORDS(WORDS),
    .BITS(BITS),
    .ADDRESS_BITS(AW)
  ) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .first(first),
    .last(last),
    .abort(abort),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
    .out_data(out_data),
    .out_addr(out_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first = f;
    last  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumes words with a repeating 4-cycle ready pattern until done is seen.
  task automatic collect(input int max_cyc, input logic [3:0] pat);
    logic            held;
    logic [BITS-1:0] hd;
    logic [AW-1:0]   ha;
    logic [AW-1:0]   hp;
    logic [1:0]      idx;
    got_addr.delete();
    got_data.delete();
    done_seen = 0;
    hd = '0;
    ha = '0;
    hp = '0;
    for (int c = 0; c < max_cyc && done_seen == 0; c++) begin
      idx       = 2'(c);
      out_ready = pat[idx];
      held      = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
      end
      if (held) begin
        hd = out_data;
        ha = out_addr;
        hp = rf_addr;
      end
      tick();
      if (held) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_data", 64'(out_data), 64'(hd));
        check_eq("hold_addr", 64'(out_addr), 64'(ha));
        check_eq("hold_ptr", 64'(rf_addr), 64'(hp));
      end
      if (done) done_seen = 1;
    end
    check_eq("done_seen", 64'(done_seen), 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic verify(input string tag, input int f, input int n);
    int ea;
    check_eq({tag, "_count"}, 64'(got_addr.size()), 64'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      ea = (f + i) % WORDS;
      check_eq({tag, "_addr"}, 64'(got_addr[i]), 64'(ea));
      check_eq({tag, "_data"}, 64'(got_data[i]), 64'(100 + ea));
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = BITS'(100 + i);
    clr       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    first     = '0;
    last      = '0;

    // Reset state
    #1 clr = 1'b0;
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_rf_addr", 64'(rf_addr), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    #10 clr = 1'b1;
    tick();

    // Basic scan 3..6, exact cycle timing
    start_scan(4'd3, 4'd6);
    check_eq("basic_busy_rise", 64'(busy), 64'd1);
    check_eq("basic_valid_k", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("basic_valid", 64'(out_valid), 64'd1);
      check_eq("basic_addr", 64'(out_addr), 64'(3 + i));
      check_eq("basic_data", 64'(out_data), 64'(103 + i));
      check_eq("basic_no_done", 64'(done), 64'd0);
    end
    tick();
    check_eq("basic_done", 64'(done), 64'd1);
    check_eq("basic_busy_fall", 64'(busy), 64'd0);
    check_eq("basic_valid_drop", 64'(out_valid), 64'd0);
    tick();
    check_eq("basic_done_pulse", 64'(done), 64'd0);

    // Wrap 14..1
    start_scan(4'd14, 4'd1);
    collect(40, 4'b1111);
    verify("wrap", 14, 4);
    check_eq("wrap_busy", 64'(busy), 64'd0);
    tick();
    check_eq("wrap_done_once", 64'(done), 64'd0);

    // Backpressure, full file, ready pattern 1,0,0,1
    start_scan(4'd0, 4'd15);
    collect(200, 4'b1001);
    verify("bp", 0, 16);
    tick();

    // Single word, then restart in the done cycle
    start_scan(4'd9, 4'd9);
    tick();
    check_eq("single_valid", 64'(out_valid), 64'd1);
    check_eq("single_addr", 64'(out_addr), 64'd9);
    check_eq("single_data", 64'(out_data), 64'd109);
    tick();
    check_eq("single_done", 64'(done), 64'd1);
    check_eq("single_busy", 64'(busy), 64'd0);
    start_scan(4'd0, 4'd0);
    check_eq("restart_busy", 64'(busy), 64'd1);
    check_eq("restart_done_low", 64'(done), 64'd0);
    tick();
    check_eq("restart_addr", 64'(out_addr), 64'd0);
    check_eq("restart_data", 64'(out_data), 64'd100);
    tick();
    check_eq("restart_done", 64'(done), 64'd1);
    tick();

    // Abort while word 5 is valid and accepted
    out_ready = 1'b1;
    start_scan(4'd0, 4'd15);
    repeat (6) tick();
    check_eq("abort_w5_valid", 64'(out_valid), 64'd1);
    check_eq("abort_w5_addr", 64'(out_addr), 64'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_valid", 64'(out_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_no_done", 64'(done), 64'd0);
    tick();
    check_eq("abort_no_done2", 64'(done), 64'd0);

    // start with abort held in IDLE must not start
    first = 4'd0;
    last  = 4'd3;
    abort = 1'b1;
    start = 1'b1;
    tick();
    check_eq("abort_start_busy", 64'(busy), 64'd0);
    tick();
    check_eq("abort_start_busy2", 64'(busy), 64'd0);
    check_eq("abort_start_valid", 64'(out_valid), 64'd0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Async reset between edges mid-scan
    out_ready = 1'b0;
    start_scan(4'd0, 4'd15);
    tick();
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    check_eq("pre_rst_rf_addr", 64'(rf_addr), 64'd1);
    #2 clr = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_rf_addr", 64'(rf_addr), 64'd0);
    check_eq("arst_out_data", 64'(out_data), 64'd0);
    #2 clr = 1'b1;
    out_ready = 1'b1;
    tick();
    start_scan(4'd2, 4'd4);
    collect(40, 4'b1111);
    verify("post_rst", 2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_reader.md
# register_file_reader

Sequential read-out engine for the dual-ported register file. On a start pulse it walks an inclusive address range, driving one register file read port, and streams each word out with its address over a valid/ready handshake at up to one word per cycle. It sits between the register file and any consumer that needs bulk register contents, such as a debug dump, a context save or a test harness, and leaves the write port and the other read port untouched.

## Interface

- WORDS, 16, number of registers in the attached register file
- BITS, 32, data word width
- ADDRESS_BITS, $clog2(WORDS), address width
- clk  input  1  clock; all state changes on the rising edge
- clr  input  1  reset; asynchronous, active-low
- start  input  1  begins a scan when the block is idle
- first  input  ADDRESS_BITS  first address of the scan; sampled on start
- last  input  ADDRESS_BITS  last address of the scan, inclusive; sampled on start
- abort  input  1  ends the current scan early
- rf_addr  output  ADDRESS_BITS  read address to the register file port
- rf_data  input  BITS  combinational read data returned for rf_addr
- out_data  output  BITS  streamed word
- out_addr  output  ADDRESS_BITS  address the streamed word was read from
- out_valid  output  1  out_data and out_addr are valid
- out_ready  input  1  consumer accepts the word this cycle
- busy  output  1  a scan is in progress (state is not IDLE)
- done  output  1  one-cycle pulse when a scan completes normally

## Operation

- **States**
  - IDLE: accepts a new scan.
  - SCAN: there are words left to read.
  - DRAIN: the last word has been loaded and is waiting to be accepted.
- **rf_addr** always equals the internal pointer `ptr`.
- **IDLE + start, with abort low**
  - Capture `ptr <= first` and `end <= last`.
  - Go to SCAN.
  - A captured value of WORDS or greater is replaced by WORDS-1.
- **Load condition**: state is SCAN and (`!out_valid || out_ready`). On a load:
  - `out_data <= rf_data`, `out_addr <= ptr`, `out_valid <= 1`.
  - If `ptr == end`, go to DRAIN.
  - Otherwise advance `ptr`. It wraps from WORDS-1 to 0; this holds even when WORDS is not a power of 2.
- **Word count** is ((last - first) mod WORDS) + 1.
  - `first == last` reads one word.
  - `last < first` wraps through 0.
  - `first = 0, last = WORDS-1` reads the whole file.
- **Output register drop**: when out_valid is high, out_ready is high and no load occurs, `out_valid <= 0`.
- **DRAIN**: on `out_valid && out_ready`:
  - `out_valid <= 0`, `done <= 1` for one cycle, go to IDLE.
- **Abort** (state not IDLE): next edge forces IDLE and `out_valid <= 0`.
  - done is not pulsed.
  - A word handshaken in the same cycle counts as delivered.
- **Abort with start in IDLE**: abort wins; no scan starts.
- **start while busy** is ignored.
- **Data is live, not a snapshot**: a register-file write that lands before a word's load edge is visible in that word.
- **Reset (clr low)** drives these values immediately, regardless of clk:
  - state IDLE, ptr 0, end 0
  - rf_addr 0, out_data 0, out_addr 0
  - out_valid 0, busy 0, done 0
- **Reset mid-scan** discards the scan; no done pulse.

## Timing

- **Start to first word**
  - start is sampled high at edge k; SCAN begins after k.
  - The first load is at edge k+1, so out_valid is high after k+1 with out_addr = first.
- **Throughput**: with out_ready held high, one word per cycle. N words occupy edges k+1 .. k+N.
- **Completion**
  - The final handshake is at edge k+N+1.
  - done is high and busy is low for the cycle after that edge.
- **Backpressure**
  - out_data, out_addr and out_valid are held stable while out_valid is high and out_ready is low.
  - ptr does not advance during backpressure.
- **Back-to-back scans**: done and IDLE occur in the same cycle, so start may be asserted in the cycle done is high.
- **busy** is registered. It rises the edge after start and falls on the same edge that done rises.

## Test plan

- **Basic scan**
  - Preload R0..R15 with 100+i. Start with first=3, last=6, out_ready=1.
  - Required: addr/data (3,103) (4,104) (5,105) (6,106) on 4 consecutive cycles, then done for one cycle and busy=0.
- **Wrap**
  - Start with first=14, last=1.
  - Required: addresses 14, 15, 0, 1 in order, 4 words, done once.
- **Backpressure**
  - Full scan 0..15 with out_ready toggled 1,0,0,1,…
  - Required: all 16 words delivered exactly once, in order.
  - Required: out_data stable during every ready-low cycle. Data matches the preload.
- **Single word and restart**
  - Start with first=last=9. Then assert start again in the done cycle with first=0, last=0.
  - Required: word (9,109), done; then word (0,100), done.
- **Abort**
  - Start 0..15 with out_ready=1; abort on the cycle word 5 is valid.
  - Required: word 5 counted as delivered. Next cycle out_valid=0, busy=0, no done.
  - Required: start with abort held high in IDLE does not start a scan.
- **Async reset**
  - Drive clr low mid-scan between clock edges.
  - Required: out_valid, busy, done, rf_addr and out_data all 0 immediately, with no clk edge needed.
  - Required: after release, a new start scans normally.
